// File: rtl/sn76489_pkg.sv
// Shared types and constants for the SN76489 DAC output path.
package sn76489_pkg;

  localparam int SAMPLE_W = 8;
  localparam int DAC_W    = 12;

  localparam logic [DAC_W-1:0] DAC_MAX = 12'hFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } dac_state_e;

endpackage

// File: rtl/sn76489_dac_scale.sv
// Combinational 8->12 bit sample scaler with saturation at full scale.
module sn76489_dac_scale
  import sn76489_pkg::*;
(
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [DAC_W-1:0]    word_o
);

  logic [DAC_W:0] sum;

  // x*16 + x/4 spreads the 8-bit range over 12 bits; only x >= 0xFD overflows.
  always_comb begin
    sum    = {1'b0, sample_i, 4'b0000} + {7'b0000000, sample_i[7:2]};
    word_o = sum[DAC_W] ? DAC_MAX : sum[DAC_W-1:0];
  end

endmodule

// File: rtl/sn76489_dac_serializer.sv
// Scales mixer samples and shifts them MSB-first into a DAC7611, with a
// one-deep pending register where the newest sample wins.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | waiting for a pending sample; dac_le high
//   ST_SHIFT | clocking 12 bits out, dac_le low
//   ST_LATCH | dac_le high for 2*CLK_DIV cycles before the next frame
module sn76489_dac_serializer
  import sn76489_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_stb,
  output logic                busy,
  output logic                dropped,
  output logic                dac_clk,
  output logic                dac_dat,
  output logic                dac_le
);

  localparam logic [4:0] HALF_M1  = 5'(CLK_DIV - 1);
  localparam logic [4:0] LATCH_M1 = 5'(2 * CLK_DIV - 1);

  dac_state_e          state_q, state_d;
  logic [SAMPLE_W-1:0] pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic                dropped_q, dropped_d;
  logic [DAC_W-1:0]    sr_q, sr_d;
  logic [3:0]          bit_q, bit_d;
  logic [4:0]          div_q, div_d;
  logic                dac_clk_q, dac_clk_d;
  logic                dac_le_q, dac_le_d;
  logic                consume;
  logic [DAC_W-1:0]    scaled;

  sn76489_dac_scale u_scale (
    .sample_i (pend_q),
    .word_o   (scaled)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    dropped_d  = 1'b0;
    sr_d       = sr_q;
    bit_d      = bit_q;
    div_d      = div_q;
    dac_clk_d  = dac_clk_q;
    dac_le_d   = dac_le_q;
    consume    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          consume   = 1'b1;
          sr_d      = scaled;
          bit_d     = 4'd11;
          div_d     = HALF_M1;
          dac_clk_d = 1'b0;
          dac_le_d  = 1'b0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_q == 5'd0) begin
          div_d = HALF_M1;
          if (!dac_clk_q) begin
            dac_clk_d = 1'b1;
          end else begin
            // End of a high phase: either advance to the next bit or latch.
            dac_clk_d = 1'b0;
            if (bit_q == 4'd0) begin
              dac_le_d = 1'b1;
              div_d    = LATCH_M1;
              state_d  = ST_LATCH;
            end else begin
              sr_d  = {sr_q[DAC_W-2:0], 1'b0};
              bit_d = bit_q - 4'd1;
            end
          end
        end else begin
          div_d = div_q - 5'd1;
        end
      end
      ST_LATCH: begin
        if (div_q == 5'd0) begin
          state_d = ST_IDLE;
        end else begin
          div_d = div_q - 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A same-cycle consume takes the old value, so the new one is not a drop.
    if (sample_stb) begin
      pend_d     = sample_in;
      pend_vld_d = 1'b1;
      dropped_d  = pend_vld_q & ~consume;
    end else if (consume) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      dropped_q  <= 1'b0;
      sr_q       <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      dac_clk_q  <= 1'b0;
      dac_le_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      dropped_q  <= dropped_d;
      sr_q       <= sr_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      dac_clk_q  <= dac_clk_d;
      dac_le_q   <= dac_le_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign dropped = dropped_q;
  assign dac_clk = dac_clk_q;
  assign dac_dat = sr_q[DAC_W-1];
  assign dac_le  = dac_le_q;

endmodule

// File: tb/tb_sn76489_dac_serializer.sv
// Random and directed stimulus against a timing-formula reference model
// plus a DAC7611 receiver model on the serial pins.
module tb_sn76489_dac_serializer;

  localparam int CD    = 2;
  localparam int FRAME = 26 * CD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_stb = 1'b0;
  logic       busy, dropped, dac_clk, dac_dat, dac_le;

  sn76489_dac_serializer #(.CLK_DIV(CD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_in  (sample_in),
    .sample_stb (sample_stb),
    .busy       (busy),
    .dropped    (dropped),
    .dac_clk    (dac_clk),
    .dac_dat    (dac_dat),
    .dac_le     (dac_le)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  int         edge_n = 0;
  int         m_free = 0;
  bit         m_vld = 0;
  logic [7:0] m_pend = 8'h00;
  bit         m_drop = 0;
  int         exp_q[$];

  // DAC7611 receiver model
  logic [11:0] rx_sr = 12'h000;
  int          rx_edges = 0;
  int          le_cyc = -1;
  int          drop_seen = 0;
  int          frames_rx = 0;
  logic        prev_clk = 1'b0;
  logic        prev_le = 1'b1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
  endtask

  function automatic int scale_ref(input int x);
    int v;
    v = x * 16 + x / 4;
    return (v > 4095) ? 4095 : v;
  endfunction

  task automatic model_edge(input bit stb, input logic [7:0] data);
    bit consumed;
    consumed = m_vld && (edge_n >= m_free);
    m_drop   = stb && m_vld && !consumed;
    if (consumed) begin
      exp_q.push_back(scale_ref(int'(m_pend)));
      m_free = edge_n + FRAME + 1;
      m_vld  = 0;
    end
    if (stb) begin
      m_pend = data;
      m_vld  = 1;
    end
  endtask

  task automatic observe();
    int want;
    check("busy", int'(busy), int'(edge_n + 1 < m_free));
    check("dropped", int'(dropped), int'(m_drop));
    if (dropped) drop_seen++;
    if (dac_clk && !prev_clk) begin
      check("le_low_at_clk", int'(dac_le), 0);
      rx_sr = {rx_sr[10:0], dac_dat};
      rx_edges++;
    end
    if (dac_le && !prev_le) begin
      le_cyc = edge_n;
      check("clk_edges", rx_edges, 12);
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
      end else begin
        want = exp_q.pop_front();
        check("dac_word", int'(rx_sr), want);
      end
      frames_rx++;
      rx_edges = 0;
    end
    prev_clk = dac_clk;
    prev_le  = dac_le;
  endtask

  task automatic step(input bit stb, input logic [7:0] data);
    sample_in  = data;
    sample_stb = stb;
    @(posedge clk);
    edge_n++;
    model_edge(stb, data);
    #1;
    sample_stb = 1'b0;
    observe();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send_and_drain(input logic [7:0] data);
    step(1'b1, data);
    idle(FRAME + 4);
  endtask

  initial begin
    int n_strobe, fall_edge, d0, wait_n;
    logic [7:0] v;

    repeat (3) @(posedge clk);
    #1;
    check("rst_dac_le", int'(dac_le), 1);
    check("rst_dac_clk", int'(dac_clk), 0);
    check("rst_dac_dat", int'(dac_dat), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dropped", int'(dropped), 0);
    rst_n = 1'b1;
    idle(3);

    // first frame with explicit edge timing
    step(1'b1, 8'h0A);
    n_strobe  = edge_n;
    fall_edge = -1;
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 8'h00);
      if (!busy && fall_edge < 0 && edge_n > n_strobe + 1) fall_edge = edge_n;
    end
    check("le_rise_edge", le_cyc, n_strobe + 1 + 24 * CD);
    check("busy_fall_edge", fall_edge, n_strobe + 1 + 26 * CD);
    check("frames_after_first", frames_rx, 1);

    send_and_drain(8'h32);
    send_and_drain(8'h00);
    send_and_drain(8'hFC);
    send_and_drain(8'hFD);
    send_and_drain(8'hFF);
    send_and_drain(8'h80);
    check("frames_directed", frames_rx, 7);

    // coalescing: 0x20 is overwritten by 0x30 while 0x10 shifts
    d0 = drop_seen;
    step(1'b1, 8'h10);
    idle(10);
    step(1'b1, 8'h20);
    idle(10);
    step(1'b1, 8'h30);
    idle(2 * FRAME + 10);
    check("coalesce_drops", drop_seen - d0, 1);
    check("frames_coalesce", frames_rx, 9);

    // strobe landing on the consume edge
    d0 = drop_seen;
    step(1'b1, 8'h44);
    step(1'b1, 8'h55);
    idle(2 * FRAME + 10);
    check("coincide_drops", drop_seen - d0, 0);
    check("frames_coincide", frames_rx, 11);

    // reset in the middle of bit 5
    step(1'b1, 8'h77);
    wait_n = 0;
    while (rx_edges < 5 && wait_n < 200) begin
      step(1'b0, 8'h00);
      wait_n++;
    end
    check("reach_bit5", int'(rx_edges >= 5), 1);
    idle(1);
    rst_n = 1'b0;
    #1;
    check("midrst_dac_le", int'(dac_le), 1);
    check("midrst_dac_clk", int'(dac_clk), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_dropped", int'(dropped), 0);
    exp_q.delete();
    m_vld    = 0;
    m_free   = 0;
    m_drop   = 0;
    rx_edges = 0;
    prev_clk = 1'b0;
    prev_le  = 1'b1;
    repeat (2) @(posedge clk);
    edge_n += 2;
    #1;
    rst_n = 1'b1;
    idle(2);
    send_and_drain(8'h32);
    check("frames_after_rst", frames_rx, 12);

    // randomized traffic
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 3))
        0:       v = 8'($urandom_range(8'hF8, 8'hFF));
        default: v = 8'($urandom_range(0, 255));
      endcase
      step(1'b1, v);
      idle($urandom_range(0, 70));
    end
    idle(2 * FRAME + 10);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
